// File: rtl/freq_meas_pkg.sv
// Shared constants and state encoding for the frequency-measurement scheduler.
package freq_meas_pkg;
   localparam int COUNT_W = 40;
   localparam int CH_NUM  = 3;

   typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH, HOLD} state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_CLK,
   input  logic i_RST_N,
   input  logic i_D,
   output logic o_Q
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= i_D;
         sync_q <= meta_q;
      end
   end

   assign o_Q = sync_q;
endmodule

// File: rtl/meas_scheduler.sv
// Sequences clear/gate/settle of three channel counters and snapshots their
// counts into SPI-visible result registers, never while a host read is active.
module meas_scheduler
   import freq_meas_pkg::*;
#(
   parameter int GATE_CYCLES   = 50_000_000,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic               i_CLK,
   input  logic               i_RST_N,
   input  logic               i_ENABLE,
   input  logic               i_SPI_CS,
   input  logic [COUNT_W-1:0] i_COUNT_A,
   input  logic [COUNT_W-1:0] i_COUNT_B,
   input  logic [COUNT_W-1:0] i_COUNT_C,
   output logic               o_GATE,
   output logic               o_CNT_CLR,
   output logic [COUNT_W-1:0] o_RESULT_A,
   output logic [COUNT_W-1:0] o_RESULT_B,
   output logic [COUNT_W-1:0] o_RESULT_C,
   output logic [CH_NUM-1:0]  o_OVF,
   output logic [7:0]         o_SEQ,
   output logic               o_DONE
);
   localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   function automatic logic is_sat(input logic [COUNT_W-1:0] cnt);
      return &cnt;
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q;
   logic [COUNT_W-1:0] res_a_q, res_b_q, res_c_q;
   logic [CH_NUM-1:0]  ovf_q;
   logic [7:0]         seq_q;
   logic               cs_s;
   logic               wr_en;
   logic               gate;
   logic               clr;

   sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
      .i_CLK   (i_CLK),
      .i_RST_N (i_RST_N),
      .i_D     (i_SPI_CS),
      .o_Q     (cs_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      gate    = 1'b0;
      clr     = 1'b0;
      case (state_q)
         IDLE:    if (i_ENABLE) state_d = CLEAR;
         CLEAR: begin
            clr     = 1'b1;
            state_d = i_ENABLE ? GATE : IDLE;
         end
         GATE: begin
            gate = 1'b1;
            if (!i_ENABLE)        state_d = IDLE;
            else if (cnt_q == '0) state_d = SETTLE;
         end
         SETTLE: begin
            if (!i_ENABLE)        state_d = IDLE;
            else if (cnt_q == '0) state_d = LATCH;
         end
         // A pending snapshot is committed regardless of i_ENABLE once here.
         LATCH: begin
            if (cs_s) begin
               wr_en   = 1'b1;
               state_d = i_ENABLE ? CLEAR : IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         HOLD:    if (cs_s) state_d = LATCH;
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) begin
         case (state_d)
            GATE:    cnt_d = GATE_LOAD;
            SETTLE:  cnt_d = SETTLE_LOAD;
            default: cnt_d = '0;
         endcase
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         res_a_q <= '0;
         res_b_q <= '0;
         res_c_q <= '0;
         ovf_q   <= '0;
         seq_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= wr_en;
         if (wr_en) begin
            res_a_q <= i_COUNT_A;
            res_b_q <= i_COUNT_B;
            res_c_q <= i_COUNT_C;
            ovf_q   <= {is_sat(i_COUNT_C), is_sat(i_COUNT_B), is_sat(i_COUNT_A)};
            seq_q   <= seq_q + 8'd1;
         end
      end
   end

   assign o_GATE     = gate;
   assign o_CNT_CLR  = clr;
   assign o_RESULT_A = res_a_q;
   assign o_RESULT_B = res_b_q;
   assign o_RESULT_C = res_c_q;
   assign o_OVF      = ovf_q;
   assign o_SEQ      = seq_q;
   assign o_DONE     = done_q;
endmodule

// File: tb/tb_meas_scheduler.sv
// Directed bench for meas_scheduler with a short gate (10) and settle (2).
module tb_meas_scheduler;
   localparam int GC = 10;
   localparam int SC = 2;
   localparam logic [39:0] SAT = 40'hFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        cs = 1'b1;
   logic [39:0] ca = '0, cb = '0, cc = '0;
   logic        o_GATE, o_CNT_CLR, o_DONE;
   logic [39:0] o_RESULT_A, o_RESULT_B, o_RESULT_C;
   logic [2:0]  o_OVF;
   logic [7:0]  o_SEQ;

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  exp_seq = '0;
   logic [39:0] exp_a = '0, exp_b = '0, exp_c = '0;
   logic [2:0]  exp_ovf = '0;

   typedef struct {
      logic [39:0] a;
      logic [39:0] b;
      logic [39:0] c;
      logic [2:0]  ovf;
   } vec_t;
   vec_t vecs[6];

   meas_scheduler #(.GATE_CYCLES(GC), .SETTLE_CYCLES(SC)) dut (
      .i_CLK      (clk),
      .i_RST_N    (rst_n),
      .i_ENABLE   (en),
      .i_SPI_CS   (cs),
      .i_COUNT_A  (ca),
      .i_COUNT_B  (cb),
      .i_COUNT_C  (cc),
      .o_GATE     (o_GATE),
      .o_CNT_CLR  (o_CNT_CLR),
      .o_RESULT_A (o_RESULT_A),
      .o_RESULT_B (o_RESULT_B),
      .o_RESULT_C (o_RESULT_C),
      .o_OVF      (o_OVF),
      .o_SEQ      (o_SEQ),
      .o_DONE     (o_DONE)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_results(input string tag);
      check({tag, ".res_a"}, 64'(o_RESULT_A), 64'(exp_a));
      check({tag, ".res_b"}, 64'(o_RESULT_B), 64'(exp_b));
      check({tag, ".res_c"}, 64'(o_RESULT_C), 64'(exp_c));
      check({tag, ".ovf"},   64'(o_OVF),      64'(exp_ovf));
      check({tag, ".seq"},   64'(o_SEQ),      64'(exp_seq));
   endtask

   task automatic run_one(input vec_t v, input string tag);
      int clr_n = 0, gate_n = 0, quiet_n = 0, cyc = 0;
      bit got = 1'b0;
      @(negedge clk);
      ca = v.a; cb = v.b; cc = v.c; en = 1'b1;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (o_DONE)         got = 1'b1;
         else if (o_CNT_CLR) clr_n++;
         else if (o_GATE)    gate_n++;
         else                quiet_n++;
      end
      en = 1'b0;
      exp_seq++; exp_a = v.a; exp_b = v.b; exp_c = v.c; exp_ovf = v.ovf;
      check({tag, ".done"}, 64'(got), 64'd1);
      check({tag, ".clr_cycles"}, 64'(clr_n), 64'd1);
      check({tag, ".gate_cycles"}, 64'(gate_n), 64'(GC));
      check({tag, ".settle_latch_cycles"}, 64'(quiet_n), 64'(SC + 1));
      check_results(tag);
      @(negedge clk);
      check({tag, ".done_width"}, 64'(o_DONE), 64'd0);
   endtask

   initial begin
      int cyc, lat, gate_n, bad, dones, consec, seq_bad, gate_total;
      bit seen, got, prev_done, wrapped;
      logic [7:0] last_seq;

      vecs[0] = '{40'd100, 40'd200, 40'd300, 3'b000};
      vecs[1] = '{40'd1, SAT, 40'd2, 3'b010};
      vecs[2] = '{40'd3, 40'd5, 40'd7, 3'b000};
      vecs[3] = '{SAT, 40'd0, SAT, 3'b101};
      vecs[4] = '{40'd0, 40'd0, 40'd0, 3'b000};
      vecs[5] = '{40'hFF_FFFF_FFFE, SAT, 40'h12_3456_789A, 3'b010};

      // reset state
      repeat (3) @(negedge clk);
      check("rst.gate", 64'(o_GATE), 64'd0);
      check("rst.clr", 64'(o_CNT_CLR), 64'd0);
      check("rst.done", 64'(o_DONE), 64'd0);
      check_results("rst");
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_one(vecs[i], $sformatf("vec%0d", i));

      // CS low across LATCH, enable dropped while holding
      @(negedge clk);
      ca = 40'd11; cb = 40'd22; cc = 40'd33; cs = 1'b0; en = 1'b1;
      cyc = 0; seen = 1'b0;
      while (cyc < 100 && !(seen && !o_GATE)) begin
         @(negedge clk);
         cyc++;
         if (o_GATE) seen = 1'b1;
      end
      check("hold.gate_fell", 64'(seen && !o_GATE), 64'd1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_GATE || o_CNT_CLR || o_DONE) bad++;
         if (o_RESULT_A !== exp_a || o_RESULT_B !== exp_b || o_RESULT_C !== exp_c || o_SEQ !== exp_seq) bad++;
         if (i == 10) en = 1'b0;
      end
      check("hold.frozen", 64'(bad), 64'd0);
      cs = 1'b1;
      lat = 0; got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (o_DONE) got = 1'b1;
      end
      check("hold.latency", 64'(lat), 64'd4);
      exp_seq++; exp_a = 40'd11; exp_b = 40'd22; exp_c = 40'd33; exp_ovf = 3'b000;
      check_results("hold");
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (o_GATE || o_CNT_CLR || o_DONE) bad++;
      end
      check("hold.idle_after", 64'(bad), 64'd0);

      // enable dropped at the fifth gate cycle
      @(negedge clk);
      ca = 40'd7; cb = 40'd8; cc = 40'd9; en = 1'b1;
      gate_n = 0; cyc = 0;
      while (gate_n < 5 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (o_GATE) gate_n++;
      end
      en = 1'b0;
      @(negedge clk);
      check("abort.gate_off", 64'(o_GATE), 64'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_GATE || o_CNT_CLR || o_DONE) bad++;
      end
      check("abort.idle", 64'(bad), 64'd0);
      check_results("abort");

      // 256 back-to-back runs
      @(negedge clk);
      ca = 40'd1; cb = 40'd2; cc = 40'd3; en = 1'b1;
      dones = 0; consec = 0; seq_bad = 0; gate_total = 0; cyc = 0;
      prev_done = 1'b0; wrapped = 1'b0; last_seq = o_SEQ;
      while (dones < 256 && cyc < 256 * 14 + 100) begin
         @(negedge clk);
         cyc++;
         if (o_GATE) gate_total++;
         if (o_DONE) begin
            if (prev_done) consec++;
            dones++;
            exp_seq++;
            if (o_SEQ !== exp_seq) seq_bad++;
            if (last_seq == 8'd255 && o_SEQ == 8'd0) wrapped = 1'b1;
            last_seq = o_SEQ;
         end
         prev_done = o_DONE;
      end
      en = 1'b0;
      @(negedge clk);
      if (o_DONE) consec++;
      exp_a = 40'd1; exp_b = 40'd2; exp_c = 40'd3; exp_ovf = 3'b000;
      check("b2b.dones", 64'(dones), 64'd256);
      check("b2b.gate_total", 64'(gate_total), 64'(256 * GC));
      check("b2b.consec_done", 64'(consec), 64'd0);
      check("b2b.seq_steps", 64'(seq_bad), 64'd0);
      check("b2b.wrap", 64'(wrapped), 64'd1);
      check_results("b2b");

      // asynchronous reset in the middle of GATE
      repeat (2) @(negedge clk);
      ca = 40'd9; cb = 40'd9; cc = 40'd9; en = 1'b1;
      gate_n = 0; cyc = 0;
      while (gate_n < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (o_GATE) gate_n++;
      end
      #2 rst_n = 1'b0;
      #1;
      exp_seq = '0; exp_a = '0; exp_b = '0; exp_c = '0; exp_ovf = '0;
      check("rstmid.gate", 64'(o_GATE), 64'd0);
      check("rstmid.clr", 64'(o_CNT_CLR), 64'd0);
      check("rstmid.done", 64'(o_DONE), 64'd0);
      check_results("rstmid");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstmid.first_clr", 64'({o_CNT_CLR, o_GATE}), 64'b10);
      got = 1'b0; cyc = 0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (o_DONE) got = 1'b1;
      end
      en = 1'b0;
      exp_seq = 8'd1; exp_a = 40'd9; exp_b = 40'd9; exp_c = 40'd9;
      check("rstmid.rerun_done", 64'(got), 64'd1);
      check_results("rstmid_rerun");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
